// File: rtl/vend_txn_sequencer.sv
// Vending machine purchase sequencer: select, coin collection with timeout,
// cancel, single-cycle vend, Rs.5 change pulse train, per-product stock.
module vend_txn_sequencer #(
    parameter int TIMEOUT_CYC = 16,
    parameter int STOCK_INIT  = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sel_vld_i,
    input  logic [1:0] sel_i,
    input  logic [1:0] coin_i,
    input  logic       cancel_i,
    input  logic       restock_i,
    output logic [2:0] prd_o,
    output logic       chg_pulse_o,
    output logic [4:0] credit_o,
    output logic       busy_o,
    output logic [2:0] sold_out_o,
    output logic       err_o
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] VEND    = 2'd2;
    localparam logic [1:0] CHANGE  = 2'd3;

    localparam logic [3:0] STOCK_RST  = 4'(STOCK_INIT);
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYC - 1);

    logic [1:0]      state_q, state_d;
    logic [4:0]      price_q, price_d;
    logic [1:0]      prod_q, prod_d;
    logic [4:0]      credit_q, credit_d;
    logic [7:0]      timer_q, timer_d;
    logic [2:0][3:0] stock_q, stock_d;
    logic [2:0]      prd_q, prd_d;
    logic            chg_q, chg_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic [2:0]      soldOut_q, soldOut_d;

    logic [4:0]      coinVal;
    logic            coinValid;
    logic [4:0]      creditNext;

    always_comb begin
        state_d   = state_q;
        price_d   = price_q;
        prod_d    = prod_q;
        credit_d  = credit_q;
        timer_d   = timer_q;
        stock_d   = stock_q;
        err_d     = 1'b0;

        case (coin_i)
            2'b01:   coinVal = 5'd5;
            2'b10:   coinVal = 5'd10;
            default: coinVal = 5'd0;
        endcase
        coinValid  = (coin_i == 2'b01) || (coin_i == 2'b10);
        creditNext = credit_q + coinVal;

        case (state_q)
            IDLE: begin
                if (coin_i != 2'b00) err_d = 1'b1;
                // Restock lands first so a same-cycle select sees the reloaded stock.
                if (restock_i) stock_d = {3{STOCK_RST}};
                if (sel_vld_i) begin
                    if (sel_i == 2'b11) begin
                        err_d = 1'b1;
                    end else if (stock_d[sel_i] == 4'd0) begin
                        err_d = 1'b1;
                    end else begin
                        case (sel_i)
                            2'b00:   price_d = 5'd5;
                            2'b01:   price_d = 5'd10;
                            default: price_d = 5'd15;
                        endcase
                        prod_d   = sel_i;
                        credit_d = 5'd0;
                        timer_d  = 8'd0;
                        state_d  = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (coin_i == 2'b11) err_d = 1'b1;
                credit_d = creditNext;
                timer_d  = coinValid ? 8'd0 : timer_q + 8'd1;
                // A refund of zero has nothing to pay out, so skip CHANGE entirely.
                if (cancel_i) begin
                    state_d = (creditNext == 5'd0) ? IDLE : CHANGE;
                end else if (creditNext >= price_q) begin
                    state_d = VEND;
                end else if (!coinValid && timer_q == TIMER_LAST) begin
                    state_d = (creditNext == 5'd0) ? IDLE : CHANGE;
                end
            end
            VEND: begin
                if (coin_i != 2'b00) err_d = 1'b1;
                stock_d[prod_q] = stock_q[prod_q] - 4'd1;
                credit_d = credit_q - price_q;
                state_d  = (credit_d != 5'd0) ? CHANGE : IDLE;
            end
            default: begin
                if (coin_i != 2'b00) err_d = 1'b1;
                credit_d = credit_q - 5'd5;
                state_d  = (credit_d == 5'd0) ? IDLE : CHANGE;
            end
        endcase

        // Output registers follow the next state so pulses line up with it.
        prd_d     = (state_d == VEND) ? 3'(3'b001 << prod_q) : 3'b000;
        chg_d     = (state_d == CHANGE);
        busy_d    = (state_d != IDLE);
        soldOut_d = {stock_d[2] == 4'd0, stock_d[1] == 4'd0, stock_d[0] == 4'd0};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            price_q   <= 5'd0;
            prod_q    <= 2'd0;
            credit_q  <= 5'd0;
            timer_q   <= 8'd0;
            stock_q   <= {3{STOCK_RST}};
            prd_q     <= 3'b000;
            chg_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            soldOut_q <= 3'b000;
        end else begin
            state_q   <= state_d;
            price_q   <= price_d;
            prod_q    <= prod_d;
            credit_q  <= credit_d;
            timer_q   <= timer_d;
            stock_q   <= stock_d;
            prd_q     <= prd_d;
            chg_q     <= chg_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            soldOut_q <= soldOut_d;
        end
    end

    assign prd_o       = prd_q;
    assign chg_pulse_o = chg_q;
    assign credit_o    = credit_q;
    assign busy_o      = busy_q;
    assign sold_out_o  = soldOut_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_vend_txn_sequencer.sv
// Directed bench for vend_txn_sequencer: inputs change #1 after a rising edge,
// outputs are checked there against hand-computed values.
module tb_vend_txn_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       selVld = 1'b0;
    logic [1:0] sel = 2'b00;
    logic [1:0] coin = 2'b00;
    logic       cancel = 1'b0;
    logic       restock = 1'b0;
    logic [2:0] prd;
    logic       chgPulse;
    logic [4:0] credit;
    logic       busy;
    logic [2:0] soldOut;
    logic       err;

    int total = 0;
    int bad = 0;
    int chgCount = 0;
    int prdCount = 0;
    int overlapCount = 0;
    int chgBase;
    int prdBase;

    vend_txn_sequencer #(.TIMEOUT_CYC(16), .STOCK_INIT(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .sel_vld_i   (selVld),
        .sel_i       (sel),
        .coin_i      (coin),
        .cancel_i    (cancel),
        .restock_i   (restock),
        .prd_o       (prd),
        .chg_pulse_o (chgPulse),
        .credit_o    (credit),
        .busy_o      (busy),
        .sold_out_o  (soldOut),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    // Pulse tallies sampled mid-cycle, used for pulse-count checks per scenario.
    always @(negedge clk) begin
        if (chgPulse) chgCount++;
        if (prd != 3'b000) prdCount++;
        if (chgPulse && prd != 3'b000) overlapCount++;
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic sv, input logic [1:0] s, input logic [1:0] c,
                                 input logic cn, input logic rs);
        selVld  = sv;
        sel     = s;
        coin    = c;
        cancel  = cn;
        restock = rs;
        @(posedge clk);
        #1;
        selVld  = 1'b0;
        sel     = 2'b00;
        coin    = 2'b00;
        cancel  = 1'b0;
        restock = 1'b0;
    endtask

    initial begin
        $display("[TB] reset with random inputs");
        rst = 1'b0;
        repeat (2) applyStimulus(1'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
        checkOutput("rst_credit", 8'(credit), 8'd0);
        checkOutput("rst_prd", 8'(prd), 8'd0);
        checkOutput("rst_chg", 8'(chgPulse), 8'd0);
        checkOutput("rst_busy", 8'(busy), 8'd0);
        checkOutput("rst_err", 8'(err), 8'd0);
        checkOutput("rst_soldout", 8'(soldOut), 8'd0);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] underpay then timeout");
        chgBase = chgCount;
        prdBase = prdCount;
        applyStimulus(1, 2'b10, 0, 0, 0);
        checkOutput("to_busy", 8'(busy), 8'd1);
        applyStimulus(0, 0, 2'b01, 0, 0);
        checkOutput("to_credit5", 8'(credit), 8'd5);
        applyStimulus(0, 0, 2'b01, 0, 0);
        checkOutput("to_credit10", 8'(credit), 8'd10);
        repeat (15) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("to_nochg_early", 8'(chgPulse), 8'd0);
        checkOutput("to_busy_wait", 8'(busy), 8'd1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("to_chg1", 8'(chgPulse), 8'd1);
        checkOutput("to_chg1_credit", 8'(credit), 8'd10);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("to_chg2", 8'(chgPulse), 8'd1);
        checkOutput("to_chg2_credit", 8'(credit), 8'd5);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("to_done_chg", 8'(chgPulse), 8'd0);
        checkOutput("to_done_credit", 8'(credit), 8'd0);
        checkOutput("to_done_busy", 8'(busy), 8'd0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("to_chg_count", 8'(chgCount - chgBase), 8'd2);
        checkOutput("to_prd_count", 8'(prdCount - prdBase), 8'd0);

        $display("[TB] overpay Rs.15 with two Rs.10");
        chgBase = chgCount;
        applyStimulus(1, 2'b10, 0, 0, 0);
        applyStimulus(0, 0, 2'b10, 0, 0);
        checkOutput("op_credit10", 8'(credit), 8'd10);
        applyStimulus(0, 0, 2'b10, 0, 0);
        checkOutput("op_prd", 8'(prd), 8'b100);
        checkOutput("op_vend_nochg", 8'(chgPulse), 8'd0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("op_prd_gone", 8'(prd), 8'd0);
        checkOutput("op_chg", 8'(chgPulse), 8'd1);
        checkOutput("op_chg_credit", 8'(credit), 8'd5);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("op_done_busy", 8'(busy), 8'd0);
        checkOutput("op_done_credit", 8'(credit), 8'd0);
        checkOutput("op_soldout", 8'(soldOut), 8'd0);
        checkOutput("op_chg_count", 8'(chgCount - chgBase), 8'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 2'b10, 0, 0, 0);
            applyStimulus(0, 0, 2'b10, 0, 0);
            applyStimulus(0, 0, 2'b01, 0, 0);
            checkOutput("op_more_prd", 8'(prd), 8'b100);
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput("op_more_idle", 8'(busy), 8'd0);
        end
        checkOutput("op_soldout15", 8'(soldOut), 8'b100);

        $display("[TB] Rs.5 sold out and restock");
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("so_restock1", 8'(soldOut), 8'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 2'b00, 0, 0, 0);
            applyStimulus(0, 0, 2'b01, 0, 0);
            checkOutput("so_prd", 8'(prd), 8'b001);
            applyStimulus(0, 0, 0, 0, 0);
        end
        checkOutput("so_soldout5", 8'(soldOut), 8'b001);
        applyStimulus(1, 2'b00, 0, 0, 0);
        checkOutput("so_sel_err", 8'(err), 8'd1);
        checkOutput("so_sel_busy", 8'(busy), 8'd0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("so_err_pulse", 8'(err), 8'd0);
        applyStimulus(1, 2'b11, 0, 0, 0);
        checkOutput("so_badsel_err", 8'(err), 8'd1);
        checkOutput("so_badsel_busy", 8'(busy), 8'd0);
        applyStimulus(1, 2'b00, 0, 0, 1);
        checkOutput("so_rsel_busy", 8'(busy), 8'd1);
        checkOutput("so_rsel_err", 8'(err), 8'd0);
        checkOutput("so_rsel_soldout", 8'(soldOut), 8'd0);
        applyStimulus(0, 0, 2'b01, 0, 0);
        checkOutput("so_rsel_prd", 8'(prd), 8'b001);
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] coin with cancel, bad coins");
        chgBase = chgCount;
        prdBase = prdCount;
        applyStimulus(1, 2'b01, 0, 0, 0);
        applyStimulus(0, 0, 2'b11, 0, 0);
        checkOutput("cc_badcoin_err", 8'(err), 8'd1);
        checkOutput("cc_badcoin_credit", 8'(credit), 8'd0);
        applyStimulus(0, 0, 2'b01, 1, 0);
        checkOutput("cc_chg", 8'(chgPulse), 8'd1);
        checkOutput("cc_credit", 8'(credit), 8'd5);
        checkOutput("cc_noprd", 8'(prd), 8'd0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("cc_done_busy", 8'(busy), 8'd0);
        applyStimulus(0, 0, 2'b10, 0, 0);
        checkOutput("cc_idlecoin_err", 8'(err), 8'd1);
        checkOutput("cc_idlecoin_credit", 8'(credit), 8'd0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("cc_chg_count", 8'(chgCount - chgBase), 8'd1);
        checkOutput("cc_prd_count", 8'(prdCount - prdBase), 8'd0);

        $display("[TB] reset during refund");
        chgBase = chgCount;
        applyStimulus(1, 2'b10, 0, 0, 0);
        applyStimulus(0, 0, 2'b10, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("rm_chg", 8'(chgPulse), 8'd1);
        checkOutput("rm_credit", 8'(credit), 8'd10);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        rst = 1'b1;
        checkOutput("rm_chg_off", 8'(chgPulse), 8'd0);
        checkOutput("rm_credit0", 8'(credit), 8'd0);
        checkOutput("rm_busy", 8'(busy), 8'd0);
        checkOutput("rm_soldout", 8'(soldOut), 8'd0);
        repeat (3) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("rm_chg_count", 8'(chgCount - chgBase), 8'd1);
        checkOutput("overlap", 8'(overlapCount), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
